// File: rtl/i2c_master_burst.sv
// Single-master I2C controller: one addressed write or read burst of 0..MAX_BYTES bytes per start.
// Outputs are registered from next-state values so SCL/SDA edges land exactly on their slot indices.
module i2c_master_burst #(
   parameter int ADDR_LEN        = 7,
   parameter int DATA_LEN        = 8,
   parameter int MAX_BYTES       = 4,
   parameter int T_LOW           = 6,
   parameter int T_HIGH          = 4,
   parameter int SETUP_SDA_START = 2,
   parameter int SETUP_SCL_START = 4,
   parameter int SETUP_SDA       = 3,
   parameter int SETUP_SDA_STOP  = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ADDR_LEN-1:0]               add_reg,
   input  logic                              R_W,
   input  logic [$clog2(MAX_BYTES+1)-1:0]    num_bytes,
   input  logic [MAX_BYTES*DATA_LEN-1:0]     wr_data,
   output logic [MAX_BYTES*DATA_LEN-1:0]     rd_data,
   output logic                              scl,
   inout  wire                               sda,
   output logic [3:0]                        state_master,
   output logic                              free,
   output logic                              done,
   output logic                              nack_err
);
   localparam int NBW      = $clog2(MAX_BYTES+1);
   localparam int P        = T_LOW + T_HIGH;
   localparam int STOP_LEN = T_LOW + SETUP_SDA_STOP + 1;
   localparam int CMAX0    = (P > SETUP_SCL_START) ? P : SETUP_SCL_START;
   localparam int CMAX     = (CMAX0 > STOP_LEN) ? CMAX0 : STOP_LEN;
   localparam int CW       = $clog2(CMAX+1);
   localparam int BMAX     = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
   localparam int BW       = $clog2(BMAX+1);

   localparam logic [CW-1:0]  C_ONE       = CW'(1);
   localparam logic [CW-1:0]  C_START_END = CW'(SETUP_SCL_START-1);
   localparam logic [CW-1:0]  C_SDA_START = CW'(SETUP_SDA_START);
   localparam logic [CW-1:0]  C_LOW       = CW'(T_LOW);
   localparam logic [CW-1:0]  C_SDA       = CW'(T_LOW-SETUP_SDA);
   localparam logic [CW-1:0]  C_SMP       = CW'(T_LOW+T_HIGH/2);
   localparam logic [CW-1:0]  C_SLOT_END  = CW'(P-1);
   localparam logic [CW-1:0]  C_STOP_END  = CW'(STOP_LEN-1);
   localparam logic [BW-1:0]  B_ONE       = BW'(1);
   localparam logic [BW-1:0]  B_ADDR_END  = BW'(ADDR_LEN-1);
   localparam logic [BW-1:0]  B_DATA_END  = BW'(DATA_LEN-1);
   localparam logic [NBW-1:0] N_ONE       = NBW'(1);
   localparam logic [NBW-1:0] NB_MAX      = NBW'(MAX_BYTES);

   typedef enum logic [3:0] {
      IDLE     = 4'b0000,
      START    = 4'b0001,
      ADDR     = 4'b0010,
      RW       = 4'b0011,
      ADDR_ACK = 4'b0100,
      WR_DATA  = 4'b0101,
      WR_ACK   = 4'b0110,
      RD_DATA  = 4'b0111,
      RD_ACK   = 4'b1000,
      STOP     = 4'b1001
   } state_t;

   state_t                        state, state_n;
   logic [CW-1:0]                 cnt, cnt_n;
   logic [BW-1:0]                 bit_cnt, bit_n;
   logic [NBW-1:0]                byte_cnt, byte_n, nb_l;
   logic [ADDR_LEN-1:0]           addr_l, ash;
   logic                          rw_l;
   logic [MAX_BYTES*DATA_LEN-1:0] wd_l, rd_q;
   logic [DATA_LEN-1:0]           shreg, wbyte, wsh;
   logic                          scl_q, sda_q, scl_n, sda_n, tx_bit;
   logic                          done_q, err_q, last_byte;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + C_ONE;
      bit_n     = bit_cnt;
      byte_n    = byte_cnt;
      last_byte = (byte_cnt + N_ONE) == nb_l;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start) state_n = START;
         end
         START: if (cnt == C_START_END) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = ADDR;
         end
         STOP: if (cnt == C_STOP_END) begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: if (cnt == C_SLOT_END) begin
            cnt_n = '0;
            case (state)
               ADDR: if (bit_cnt == B_ADDR_END) begin
                  bit_n   = '0;
                  state_n = RW;
               end else bit_n = bit_cnt + B_ONE;
               RW: state_n = ADDR_ACK;
               ADDR_ACK: begin
                  bit_n  = '0;
                  byte_n = '0;
                  if (shreg[0] || nb_l == '0) state_n = STOP;
                  else                        state_n = rw_l ? RD_DATA : WR_DATA;
               end
               WR_DATA, RD_DATA: if (bit_cnt == B_DATA_END) begin
                  bit_n   = '0;
                  state_n = (state == WR_DATA) ? WR_ACK : RD_ACK;
               end else bit_n = bit_cnt + B_ONE;
               WR_ACK: begin
                  byte_n = byte_cnt + N_ONE;
                  if (shreg[0] || last_byte) state_n = STOP;
                  else                       state_n = WR_DATA;
               end
               RD_ACK: begin
                  byte_n  = byte_cnt + N_ONE;
                  state_n = last_byte ? STOP : RD_DATA;
               end
               default: state_n = IDLE;
            endcase
         end
      endcase

      // bit the master will present once the upcoming slot reaches its SDA change index
      wbyte = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         if (byte_n == NBW'(i)) wbyte = wd_l[i*DATA_LEN +: DATA_LEN];
      wsh = wbyte << bit_n;
      ash = addr_l << bit_n;
      case (state_n)
         ADDR:    tx_bit = ash[ADDR_LEN-1];
         RW:      tx_bit = rw_l;
         WR_DATA: tx_bit = wsh[DATA_LEN-1];
         RD_ACK:  tx_bit = (byte_n + N_ONE) == nb_l;
         STOP:    tx_bit = 1'b0;
         default: tx_bit = 1'b1;
      endcase

      scl_n = (cnt_n >= C_LOW);
      sda_n = (cnt_n == C_SDA) ? tx_bit : sda_q;
      case (state_n)
         IDLE: begin
            scl_n = 1'b1;
            sda_n = 1'b1;
         end
         START: begin
            scl_n = 1'b1;
            sda_n = (cnt_n < C_SDA_START);
         end
         STOP: if (cnt_n == C_STOP_END) sda_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         nb_l     <= '0;
         addr_l   <= '0;
         rw_l     <= 1'b0;
         wd_l     <= '0;
         rd_q     <= '0;
         shreg    <= '0;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         scl_q    <= scl_n;
         sda_q    <= sda_n;
         done_q   <= (state == STOP) && (state_n == IDLE);
         if (state == IDLE && start) begin
            addr_l <= add_reg;
            rw_l   <= R_W;
            nb_l   <= (num_bytes > NB_MAX) ? NB_MAX : num_bytes;
            wd_l   <= wr_data;
            rd_q   <= '0;
            err_q  <= 1'b0;
         end
         // the shift register doubles as the ACK sample: bit 0 holds the latest SDA read
         if (state != IDLE && state != START && state != STOP && cnt == C_SMP)
            shreg <= {shreg[DATA_LEN-2:0], sda};
         if ((state == ADDR_ACK || state == WR_ACK) && cnt == C_SLOT_END && shreg[0])
            err_q <= 1'b1;
         if (state == RD_DATA && cnt == C_SLOT_END && bit_cnt == B_DATA_END)
            for (int i = 0; i < MAX_BYTES; i++)
               if (byte_cnt == NBW'(i)) rd_q[i*DATA_LEN +: DATA_LEN] <= shreg;
      end
   end

   assign sda          = sda_q ? 1'bz : 1'b0;
   assign scl          = scl_q;
   assign state_master = state;
   assign free         = (state == IDLE);
   assign done         = done_q;
   assign nack_err     = err_q;
   assign rd_data      = rd_q;
endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst: a bus-level slave model answers the master and logs every bit slot.
`timescale 1ns/1ps
module tb_i2c_master_burst;
   localparam int PER = 10;

   logic        clk = 1'b0;
   logic        rst, start, R_W;
   logic [6:0]  add_reg;
   logic [2:0]  num_bytes;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        scl, free, done, nack_err;
   logic [3:0]  state_master;
   wire         sda;

   i2c_master_burst dut (
      .clk(clk), .rst(rst), .start(start), .add_reg(add_reg), .R_W(R_W),
      .num_bytes(num_bytes), .wr_data(wr_data), .rd_data(rd_data), .scl(scl),
      .sda(sda), .state_master(state_master), .free(free), .done(done), .nack_err(nack_err)
   );

   always #(PER/2) clk = ~clk;

   // slave model
   logic       slv_low = 1'b0;
   assign sda = slv_low ? 1'b0 : 1'bz;
   pullup (sda);

   bit         active = 1'b0;
   bit         rw_seen = 1'b0;
   bit         got_scl_fall = 1'b0;
   int         slot = 0;
   int         nslots = -1;
   logic       bus_bits [64];
   time        t_sda_fall, t_scl_rise;
   int         start_gap = 0, stop_gap = 0;
   logic       cfg_addr_ack = 1'b1;
   int         cfg_nack_byte = -1;
   int         cfg_nrd = 0;
   logic [7:0] cfg_rd [4];

   int checks = 0, passes = 0, fails = 0;

   function automatic logic slv_pull(input int s);
      int j, p;
      if (s == 8) return cfg_addr_ack;
      if (s < 9) return 1'b0;
      j = (s - 9) / 9;
      p = (s - 9) % 9;
      if (!rw_seen) return (p == 8) && (j != cfg_nack_byte);
      if (p < 8 && j < cfg_nrd) return !cfg_rd[j][7-p];
      return 1'b0;
   endfunction

   function automatic logic [7:0] get_byte(input int base);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bus_bits[base+i]};
      return b;
   endfunction

   always @(negedge sda) if (scl === 1'b1) begin
      active = 1'b1; slot = -1; slv_low = 1'b0;
      t_sda_fall = $time; got_scl_fall = 1'b0;
   end

   always @(posedge sda) if (scl === 1'b1 && active) begin
      active = 1'b0; slv_low = 1'b0; nslots = slot;
      stop_gap = int'(($time - t_scl_rise) / PER);
   end

   always @(posedge scl) begin
      t_scl_rise = $time;
      if (active && slot >= 0 && slot < 64) bus_bits[slot] = sda;
      if (active && slot == 7) rw_seen = sda;
   end

   always @(negedge scl) if (active) begin
      if (!got_scl_fall) begin
         got_scl_fall = 1'b1;
         start_gap = int'(($time - t_sda_fall) / PER);
      end
      slot++;
      slv_low = slv_pull(slot);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // one transaction; counts non-IDLE cycles until done; optionally disturbs inputs mid-flight
   task automatic run(input int repulse_at, output int len);
      int n = 0;
      len = 0;
      nslots = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (done !== 1'b1 && n < 2000) begin
         if (free === 1'b0) len++;
         if (n == repulse_at) begin
            start = 1'b1; add_reg = 7'h7F; num_bytes = 3'd3; R_W = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("no_timeout", 32'(n < 2000), 32'd1);
   endtask

   initial begin
      int len;
      rst = 1'b1; start = 1'b0; add_reg = '0; R_W = 1'b0; num_bytes = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_free", 32'(free), 32'd1);
      chk("rst_scl", 32'(scl), 32'd1);
      chk("rst_sda", 32'(sda), 32'd1);
      chk("rst_state", 32'(state_master), 32'd0);
      chk("rst_nack", 32'(nack_err), 32'd0);
      chk("rst_rd", rd_data, 32'd0);

      // two-byte write, all ACKed
      add_reg = 7'h56; R_W = 1'b0; num_bytes = 3'd2; wr_data = 32'h0000CDAB;
      run(-1, len);
      chk("wr_len", 32'(len), 32'd283);
      chk("wr_nack", 32'(nack_err), 32'd0);
      chk("wr_addr", 32'(get_byte(0)), 32'hAC);
      chk("wr_b0", 32'(get_byte(9)), 32'hAB);
      chk("wr_b1", 32'(get_byte(18)), 32'hCD);
      chk("wr_slots", 32'(nslots), 32'd27);
      chk("start_gap", 32'(start_gap), 32'd2);
      chk("stop_gap", 32'(stop_gap), 32'd2);

      // three-byte read
      cfg_rd[0] = 8'h11; cfg_rd[1] = 8'h22; cfg_rd[2] = 8'h33; cfg_nrd = 3;
      R_W = 1'b1; num_bytes = 3'd3;
      run(-1, len);
      chk("rd_len", 32'(len), 32'd373);
      chk("rd_data", rd_data, 32'h00332211);
      chk("rd_addr", 32'(get_byte(0)), 32'hAD);
      chk("rd_mack0", 32'(bus_bits[17]), 32'd0);
      chk("rd_mack1", 32'(bus_bits[26]), 32'd0);
      chk("rd_mnack2", 32'(bus_bits[35]), 32'd1);
      chk("rd_slots", 32'(nslots), 32'd36);
      chk("rd_nack", 32'(nack_err), 32'd0);
      cfg_nrd = 0;

      // address NACK
      cfg_addr_ack = 1'b0; R_W = 1'b0; num_bytes = 3'd2;
      run(-1, len);
      chk("an_len", 32'(len), 32'd103);
      chk("an_nack", 32'(nack_err), 32'd1);
      chk("an_slots", 32'(nslots), 32'd9);
      cfg_addr_ack = 1'b1;

      // data NACK on byte 1 of 3
      cfg_nack_byte = 1; num_bytes = 3'd3; wr_data = 32'h00332211;
      run(-1, len);
      chk("dn_len", 32'(len), 32'd283);
      chk("dn_nack", 32'(nack_err), 32'd1);
      chk("dn_slots", 32'(nslots), 32'd27);
      chk("dn_b1", 32'(get_byte(18)), 32'h22);
      cfg_nack_byte = -1;

      // address-only probe, with start re-pulsed and inputs changed mid-transfer
      add_reg = 7'h56; R_W = 1'b0; num_bytes = 3'd0;
      run(40, len);
      chk("pr_len", 32'(len), 32'd103);
      chk("pr_slots", 32'(nslots), 32'd9);
      chk("pr_addr", 32'(get_byte(0)), 32'hAC);
      chk("pr_nack", 32'(nack_err), 32'd0);
      chk("pr_idle", 32'(free), 32'd1);

      // byte count above MAX_BYTES clamps to 4
      add_reg = 7'h56; R_W = 1'b0; num_bytes = 3'd7; wr_data = 32'h44332211;
      run(-1, len);
      chk("cl_len", 32'(len), 32'd463);
      chk("cl_slots", 32'(nslots), 32'd45);
      chk("cl_b3", 32'(get_byte(36)), 32'h44);

      // reset during WR_DATA
      num_bytes = 3'd2;
      begin
         int n = 0;
         int dones = 0;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         while (state_master !== 4'b0101 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("mr_reach_wr", 32'(n < 500), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         chk("mr_scl", 32'(scl), 32'd1);
         chk("mr_sda", 32'(sda), 32'd1);
         chk("mr_state", 32'(state_master), 32'd0);
         chk("mr_done", 32'(done), 32'd0);
         rst = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
         end
         chk("mr_no_done", 32'(dones), 32'd0);
         chk("mr_free", 32'(free), 32'd1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
